bcd_display_loader: RTL and testbench

//  Sequential binary-to-BCD front end for the 4-digit 7-segment path.
//  - Accepts an unsigned binary value over a valid/ready handshake.
//  - Converts it with iterative double-dabble (shift-add-3, one bit per cycle).
//  - Applies leading-zero blanking and overflow substitution.
//  - Holds the resulting digit array and blank mask stable for the digit multiplexer until the next conversion completes.

---
 rtl/bcd_display_loader_if.sv | 22 ++
 rtl/bcd_display_loader.sv | 124 ++++++++++++
 tb/tb_bcd_display_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bcd_display_loader_if.sv
// Handshake and display-result bundle between a binary value source and the BCD loader.
interface bcd_display_loader_if #(
    parameter int WIDTH = 14
);
    logic [WIDTH-1:0] bin_value;
    logic             bin_valid;
    logic             bin_ready;
    logic [3:0][3:0]  number;
    logic [3:0]       blank;
    logic             ovf;
    logic             done;

    modport master (
        output bin_value, bin_valid,
        input  bin_ready, number, blank, ovf, done
    );

    modport slave (
        input  bin_value, bin_valid,
        output bin_ready, number, blank, ovf, done
    );
endinterface

// File: rtl/bcd_display_loader.sv
// Sequential double-dabble binary-to-BCD converter feeding the 4-digit display mux,
// with leading-zero blanking and dash substitution for values above 9999.
//
// state | meaning
// IDLE  | ready for a new value; last result held on the outputs
// SHIFT | one add-3/shift step per cycle, WIDTH steps total
// LOAD  | publish digits, blank mask and ovf; pulse done next cycle
module bcd_display_loader #(
    parameter int WIDTH         = 14,
    parameter bit BLANK_LEADING = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    bcd_display_loader_if.slave bus
);
    localparam int         CW        = $clog2(WIDTH + 1);
    localparam logic [3:0] BLANK_RST = BLANK_LEADING ? 4'b1110 : 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] bin_sr;
    logic [15:0]      bcd;
    logic [15:0]      bcd_adj;
    logic [CW-1:0]    bit_cnt;
    logic             ovf_pend;
    logic             ready_c;
    logic [3:0]       blank_calc;
    logic [3:0][3:0]  number_q;
    logic [3:0]       blank_q;
    logic             ovf_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        case (state)
            IDLE: begin
                ready_c = ~reset;
                if (bus.bin_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt == CW'(WIDTH - 1)) state_nxt = LOAD;
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-nibble correction; nibbles never carry into each other.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        blank_calc = 4'b0000;
        if (BLANK_LEADING) begin
            blank_calc[3] = (bcd[15:12] == 4'd0);
            blank_calc[2] = blank_calc[3] && (bcd[11:8] == 4'd0);
            blank_calc[1] = blank_calc[2] && (bcd[7:4] == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_sr   <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            ovf_pend <= 1'b0;
            number_q <= '0;
            blank_q  <= BLANK_RST;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.bin_valid) begin
                        bin_sr   <= bus.bin_value;
                        bcd      <= '0;
                        bit_cnt  <= '0;
                        ovf_pend <= (32'(bus.bin_value) > 32'd9999);
                    end
                end
                SHIFT: begin
                    {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    bit_cnt       <= bit_cnt + CW'(1);
                end
                LOAD: begin
                    done_q <= 1'b1;
                    if (ovf_pend) begin
                        number_q <= '1;
                        blank_q  <= 4'b0000;
                        ovf_q    <= 1'b1;
                    end else begin
                        number_q <= bcd;
                        blank_q  <= blank_calc;
                        ovf_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bin_ready = ready_c;
    assign bus.number    = number_q;
    assign bus.blank     = blank_q;
    assign bus.ovf       = ovf_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bcd_display_loader.sv
// Directed plus randomized bench for bcd_display_loader; both blanking variants run in lockstep.
module tb_bcd_display_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] bin_value;
    logic        bin_valid;
    int          total  = 0;
    int          passed = 0;

    bcd_display_loader_if #(.WIDTH(14)) bus1 ();
    bcd_display_loader_if #(.WIDTH(14)) bus0 ();

    assign bus1.bin_value = bin_value;
    assign bus1.bin_valid = bin_valid;
    assign bus0.bin_value = bin_value;
    assign bus0.bin_valid = bin_valid;

    bcd_display_loader #(.WIDTH(14), .BLANK_LEADING(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    bcd_display_loader #(.WIDTH(14), .BLANK_LEADING(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_number(input int v);
        if (v > 9999) return 16'hFFFF;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] exp_blank(input int v, input bit bl);
        if (v > 9999 || !bl) return 4'b0000;
        return {v < 1000, v < 100, v < 10, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus1.bin_ready && n < 40) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(bus1.bin_ready), 32'd1);
    endtask

    task automatic check_result(input string tag, input int v);
        chk({tag, "_num1"},   32'(bus1.number), 32'(exp_number(v)));
        chk({tag, "_blank1"}, 32'(bus1.blank),  32'(exp_blank(v, 1'b1)));
        chk({tag, "_ovf1"},   32'(bus1.ovf),    32'(v > 9999));
        chk({tag, "_num0"},   32'(bus0.number), 32'(exp_number(v)));
        chk({tag, "_blank0"}, 32'(bus0.blank),  32'(exp_blank(v, 1'b0)));
    endtask

    // Waits for done after a handshake, checking latency and that old results hold meanwhile.
    task automatic wait_done(input string tag, input int v, input int prev_v);
        int k = 0;
        bit seen = 1'b0;
        while (!seen && k < 40) begin
            step();
            k++;
            if (k == 7) begin
                chk({tag, "_hold_num"},   32'(bus1.number), 32'(exp_number(prev_v)));
                chk({tag, "_hold_blank"}, 32'(bus1.blank),  32'(exp_blank(prev_v, 1'b1)));
            end
            if (bus1.done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(k), 32'd15);
        check_result(tag, v);
    endtask

    task automatic convert(input string tag, input int v, input int prev_v);
        wait_ready();
        bin_value = 14'(v);
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        bin_value = 14'($urandom);
        wait_done(tag, v, prev_v);
        step();
        chk({tag, "_done_pulse"}, 32'(bus1.done), 32'd0);
    endtask

    initial begin
        int prev;
        int v;
        int k;
        int hs;
        int low;
        int dcount;

        reset     = 1'b1;
        bin_value = '0;
        bin_valid = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(bus1.bin_ready), 32'd0);
        reset = 1'b0;
        check_result("rst", 0);
        chk("rst_done", 32'(bus1.done), 32'd0);

        prev = 0;
        convert("v1234", 1234, prev);  prev = 1234;
        convert("v7", 7, prev);        prev = 7;
        convert("v0", 0, prev);        prev = 0;
        convert("v9999", 9999, prev);  prev = 9999;
        convert("v10000", 10000, prev); prev = 10000;
        convert("v16383", 16383, prev); prev = 16383;
        convert("v42", 42, prev);      prev = 42;

        // Back-to-back handshakes with bin_valid held high.
        wait_ready();
        bin_value = 14'd12;
        bin_valid = 1'b1;
        step();
        bin_value = 14'd345;
        k = 0; hs = 0; low = 0;
        while (hs == 0 && k < 40) begin
            if (bus1.bin_ready) begin
                hs = k + 1;
                check_result("b2b_first", 12);
                chk("b2b_first_done", 32'(bus1.done), 32'd1);
            end else begin
                low++;
            end
            step();
            k++;
        end
        bin_valid = 1'b0;
        chk("b2b_spacing", 32'(hs), 32'd16);
        chk("b2b_ready_low", 32'(low), 32'd15);
        wait_done("b2b_second", 345, 12);
        prev = 345;

        // Reset in the middle of a conversion.
        wait_ready();
        bin_value = 14'd5678;
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        check_result("midrst", 0);
        chk("midrst_done", 32'(bus1.done), 32'd0);
        chk("midrst_ready", 32'(bus1.bin_ready), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("midrst_ready_after", 32'(bus1.bin_ready), 32'd1);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus1.done || bus0.done) dcount++;
            step();
        end
        chk("midrst_no_done", 32'(dcount), 32'd0);
        check_result("midrst_held", 0);
        prev = 0;

        // Randomized values, biased toward the 9999/10000 boundary every few draws.
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 3) v = int'($urandom_range(9990, 10010));
            else            v = int'($urandom_range(0, 16383));
            convert("rand", v, prev);
            prev = v;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
